// File: rtl/scaler_readout_ctrl.sv
// Scaler readout sequencer: on each PPS rising edge, pulses the scaler
// latch/clear line, snapshots every channel into a shadow register and
// streams the snapshot out one channel per ready/valid transfer.
// A PPS edge arriving while a readout is still in progress is counted
// as a dropped second in drops_o (saturating at 255).
//
// Build option: SCALER_READOUT_SATFLAG_EN widens data_o by one bit.
// That extra bit flags a channel whose shadowed value is all ones.
//
// state | meaning
// IDLE  | waiting for a PPS edge
// PULSE | scaler latch/clear pulse in flight
// SNAP  | scalers settling; snapshot taken on exit
// SEND  | streaming shadow words, channel 0..NCHAN-1
module scaler_readout_ctrl #(
   parameter int NCHAN = 8,
   parameter int WIDTH = 8,
`ifdef SCALER_READOUT_SATFLAG_EN
   localparam int DW = WIDTH + 1
`else
   localparam int DW = WIDTH
`endif
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   pps_i,
   input  logic [NCHAN*WIDTH-1:0] scalers_i,
   output logic                   scaler_pps_o,
   output logic [DW-1:0]          data_o,
   output logic [5:0]             chan_o,
   output logic                   last_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic                   busy_o,
   output logic [7:0]             drops_o,
   input  logic                   clear_i
);

   typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_SNAP, ST_SEND} state_t;

   state_t                 state_q;
   logic                   pps_q;
   logic                   spps_q;
   logic                   valid_q;
   logic                   last_q;
   logic [5:0]             chan_q;
   logic [7:0]             drops_q, drops_d;
   logic [NCHAN*WIDTH-1:0] shadow_q;
   logic [WIDTH-1:0]       data_word;

   logic pps_edge;
   logic xfer;
   logic drop;

   assign pps_edge = pps_i & ~pps_q;
   assign xfer     = valid_q & ready_i;
   assign drop     = pps_edge & (state_q != ST_IDLE);

   // PPS history; resets high so a level already high at release is not an edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) pps_q <= 1'b1;
      else       pps_q <= pps_i;
   end

   // Sequencer FSM with registered pulse, valid, last, channel and shadow.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         spps_q   <= 1'b0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         chan_q   <= 6'd0;
         shadow_q <= '0;
      end else begin
         spps_q <= pps_edge;
         case (state_q)
            ST_IDLE: begin
               if (pps_edge) state_q <= ST_PULSE;
            end
            ST_PULSE: begin
               state_q <= ST_SNAP;
            end
            ST_SNAP: begin
               state_q  <= ST_SEND;
               shadow_q <= scalers_i;
               valid_q  <= 1'b1;
               chan_q   <= 6'd0;
               last_q   <= 1'b0;
            end
            ST_SEND: begin
               if (xfer) begin
                  if (last_q) begin
                     state_q <= ST_IDLE;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     chan_q  <= 6'd0;
                  end else begin
                     chan_q <= chan_q + 6'd1;
                     last_q <= (chan_q == 6'(NCHAN - 2));
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Drop counter next value: a clear coinciding with a drop leaves one count.
   always_comb begin
      drops_d = drops_q;
      if (clear_i)                        drops_d = drop ? 8'd1 : 8'd0;
      else if (drop && drops_q != 8'hFF)  drops_d = drops_q + 8'd1;
   end

   // Drop counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) drops_q <= 8'd0;
      else       drops_q <= drops_d;
   end

   // Output word is always taken from the snapshot, never from live scalers.
   always_comb begin
      data_word = shadow_q[int'(chan_q)*WIDTH +: WIDTH];
   end

`ifdef SCALER_READOUT_SATFLAG_EN
   assign data_o = {&data_word, data_word};
`else
   assign data_o = data_word;
`endif

   assign scaler_pps_o = spps_q;
   assign chan_o       = chan_q;
   assign last_o       = last_q;
   assign valid_o      = valid_q;
   assign busy_o       = (state_q != ST_IDLE);
   assign drops_o      = drops_q;

endmodule

// File: tb/tb_scaler_readout_ctrl.sv
// Directed bench for scaler_readout_ctrl (NCHAN=8, WIDTH=8).
module tb_scaler_readout_ctrl;

   localparam int NCHAN = 8;
   localparam int WIDTH = 8;
`ifdef SCALER_READOUT_SATFLAG_EN
   localparam int DW = WIDTH + 1;
`else
   localparam int DW = WIDTH;
`endif

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   pps;
   logic [NCHAN*WIDTH-1:0] scal;
   logic                   spps;
   logic [DW-1:0]          data;
   logic [5:0]             chan;
   logic                   last;
   logic                   valid;
   logic                   ready;
   logic                   busy;
   logic [7:0]             drops;
   logic                   clear;

   int checks = 0;
   int errors = 0;

   scaler_readout_ctrl #(.NCHAN(NCHAN), .WIDTH(WIDTH)) dut (
      .clk_i(clk), .rst_i(rst), .pps_i(pps), .scalers_i(scal),
      .scaler_pps_o(spps), .data_o(data), .chan_o(chan), .last_o(last),
      .valid_o(valid), .ready_i(ready), .busy_o(busy), .drops_o(drops),
      .clear_i(clear)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       pps, ready, clear;
      logic       valid;
      logic [5:0] chan;
      logic [7:0] data;
      logic       last, busy, spps;
      logic [7:0] drops;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic p, input logic r, input logic c,
                               input logic v, input int ch, input int d,
                               input logic l, input logic b, input logic s,
                               input int dr);
      vec_t e;
      e.pps = p; e.ready = r; e.clear = c; e.valid = v;
      e.chan = 6'(ch); e.data = 8'(d); e.last = l; e.busy = b;
      e.spps = s; e.drops = 8'(dr);
      vecs.push_back(e);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive inputs, take one rising edge, then sample 1 time unit later.
   task automatic step(input logic p, input logic r, input logic c);
      pps = p; ready = r; clear = c;
      @(posedge clk);
      #1;
   endtask

   task automatic set_default_scalers();
      for (int n = 0; n < NCHAN; n++) scal[n*WIDTH +: WIDTH] = 8'(n + 1);
   endtask

   function automatic logic [31:0] exp_word(input logic [7:0] v);
`ifdef SCALER_READOUT_SATFLAG_EN
      return {23'd0, &v, v};
`else
      return {24'd0, v};
`endif
   endfunction

   initial begin
      rst = 1'b1; pps = 1'b0; ready = 1'b0; clear = 1'b0;
      set_default_scalers();

      // normal readout frame
      add(0,1,0, 0,0,0,0,0,0,0);
      add(1,1,0, 0,0,0,0,1,1,0);
      add(1,1,0, 0,0,0,0,1,0,0);
      for (int n = 0; n < 8; n++) add(1,1,0, 1,n,n+1,(n==7),1,0,0);
      add(1,1,0, 0,0,0,0,0,0,0);
      // backpressure frame: stall five cycles on channel 3
      add(0,1,0, 0,0,0,0,0,0,0);
      add(1,1,0, 0,0,0,0,1,1,0);
      add(1,1,0, 0,0,0,0,1,0,0);
      add(1,1,0, 1,0,1,0,1,0,0);
      for (int n = 1; n < 4; n++) add(1,1,0, 1,n,n+1,0,1,0,0);
      for (int k = 0; k < 5; k++) add(1,0,0, 1,3,4,0,1,0,0);
      for (int n = 4; n < 8; n++) add(1,1,0, 1,n,n+1,(n==7),1,0,0);
      add(1,1,0, 0,0,0,0,0,0,0);

      // reset state
      @(posedge clk); @(posedge clk); #1;
      chk("rst valid", 32'(valid), 0);
      chk("rst spps",  32'(spps),  0);
      chk("rst busy",  32'(busy),  0);
      chk("rst drops", 32'(drops), 0);
      chk("rst chan",  32'(chan),  0);
      chk("rst data",  32'(data),  0);
      chk("rst last",  32'(last),  0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t v;
         v = vecs[i];
         step(v.pps, v.ready, v.clear);
         chk($sformatf("v%0d valid", i), 32'(valid), 32'(v.valid));
         chk($sformatf("v%0d busy",  i), 32'(busy),  32'(v.busy));
         chk($sformatf("v%0d spps",  i), 32'(spps),  32'(v.spps));
         chk($sformatf("v%0d last",  i), 32'(last),  32'(v.last));
         chk($sformatf("v%0d drops", i), 32'(drops), 32'(v.drops));
         if (v.valid) begin
            chk($sformatf("v%0d chan", i), 32'(chan), 32'(v.chan));
            chk($sformatf("v%0d data", i), 32'(data), exp_word(v.data));
         end
      end

      // drop during SEND with stalled consumer; live scalers change
      step(0,0,0); step(1,0,0); step(1,0,0); step(1,0,0);
      chk("drop pre valid", 32'(valid), 1);
      chk("drop pre data",  32'(data),  exp_word(8'd1));
      for (int n = 0; n < NCHAN; n++) scal[n*WIDTH +: WIDTH] = 8'h55;
      step(0,0,0); step(1,0,0);
      chk("drop spps",  32'(spps),  1);
      chk("drop drops", 32'(drops), 1);
      chk("drop chan",  32'(chan),  0);
      chk("drop data",  32'(data),  exp_word(8'd1));
      for (int n = 1; n < NCHAN; n++) begin
         step(1,1,0);
         chk($sformatf("drop frame chan%0d", n), 32'(chan), 32'(n));
         chk($sformatf("drop frame data%0d", n), 32'(data), exp_word(8'(n + 1)));
         chk($sformatf("drop frame last%0d", n), 32'(last), 32'(n == NCHAN - 1));
      end
      step(1,1,0);
      chk("drop end valid", 32'(valid), 0);
      chk("drop end busy",  32'(busy),  0);
      set_default_scalers();

      // clear alone, then clear coinciding with a drop
      step(1,0,1);
      chk("clear drops", 32'(drops), 0);
      step(0,0,0); step(1,0,0); step(1,0,0); step(1,0,0);
      step(0,0,0); step(1,0,0);
      chk("drop2 drops", 32'(drops), 1);
      step(0,0,0); step(1,0,1);
      chk("clear+drop drops", 32'(drops), 1);

      // saturate the drop counter while stalled in SEND
      for (int k = 0; k < 300; k++) begin
         step(0,0,0); step(1,0,0);
      end
      chk("sat spps",  32'(spps),  1);
      chk("sat drops", 32'(drops), 255);
      chk("sat valid", 32'(valid), 1);
      chk("sat chan",  32'(chan),  0);
      chk("sat data",  32'(data),  exp_word(8'd1));

      // asynchronous reset in the middle of SEND
      #2 rst = 1'b1;
      #1;
      chk("midrst valid", 32'(valid), 0);
      chk("midrst drops", 32'(drops), 0);
      chk("midrst busy",  32'(busy),  0);
      chk("midrst spps",  32'(spps),  0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step(1,1,0);
         chk($sformatf("post rst valid%0d", k), 32'(valid), 0);
         chk($sformatf("post rst spps%0d",  k), 32'(spps),  0);
         chk($sformatf("post rst busy%0d",  k), 32'(busy),  0);
      end

      // all-ones channel 2
      scal[2*WIDTH +: WIDTH] = 8'hFF;
      step(0,1,0); step(1,1,0); step(1,1,0); step(1,1,0);
      for (int n = 0; n < NCHAN; n++) begin
         logic [7:0] ev;
         ev = (n == 2) ? 8'hFF : 8'(n + 1);
         chk($sformatf("ones chan%0d", n), 32'(chan), 32'(n));
         chk($sformatf("ones data%0d", n), 32'(data), exp_word(ev));
         if (n < NCHAN - 1) step(1,1,0);
      end
      step(1,1,0);
      chk("ones end valid", 32'(valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
